stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised successor to the single-rocket stage manager: sequences NUM_STAGES burn phases from packed parameter tables.
- Runs an internal burn timer with optional automatic cutoff, a separation delay between stages, and an abort mode.
- Drives the per-stage parameter bus (Isp, initial mass, propellant mass, burn time) consumed by the trajectory/thrust integrator.
- Sits between the mission top-level and that integrator.

Parameters:
- N, 64, datapath width of every table entry and parameter output.
- NUM_STAGES, 4, number of burn phases; a re-ignition counts as its own phase. Range 1..15.
- STAGE_W, 4, width of the stage output; 2**STAGE_W > NUM_STAGES.
- TICKS_PER_SEC, 10, clk cycles per simulated second.
- SEP_CYCLES, 3, clk cycles spent in SEP between phases; 0 is legal (SEP lasts 1 cycle).
- AUTO_CUTOFF, 1, 1 = burn also ends when elapsed seconds reach burntime.
- PAYLOAD, 27003, payload mass (LM + CSM), always carried.
- ISP_TABLE, NUM_STAGES*N bits, Isp per phase; phase k occupies bits [(k-1)*N +: N].
- PROP_TABLE, NUM_STAGES*N bits, propellant mass per phase, same layout.
- BURN_TABLE, NUM_STAGES*N bits, burn time in seconds per phase, same layout.
- DRY_TABLE, NUM_STAGES*N bits, dry mass jettisoned after phase k; 0 for a phase followed by a re-ignition of the same hardware.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- launch, input, 1, start pulse; honoured only in IDLE.
- ignition_end, input, 1, external engine cutoff; honoured only in BURN.
- abort, input, 1, mission abort; honoured in LOAD/BURN/SEP.
- stage, output, STAGE_W, current phase, 0 = not launched.
- specific_impulse, output, N, Isp of current phase.
- initial_weight, output, N, vehicle mass at ignition of current phase.
- weight_propellant, output, N, propellant of current phase.
- burntime, output, N, burn time of current phase.
- stage_valid, output, 1, one-cycle pulse when new parameters appear.
- burning, output, 1, high in BURN.
- elapsed_sec, output, N, whole seconds elapsed in current burn.
- mission_done, output, 1, sticky after the last phase completes.
- aborted, output, 1, sticky abort flag.

Behaviour:
- Reset (sync, active-high), outputs: stage=0, specific_impulse=0, initial_weight=0, weight_propellant=0, burntime=1, elapsed_sec=0, all 1-bit outputs 0, state=IDLE. Reset in any state takes effect at the next edge and clears the sticky flags.
- initial_weight(k) = PAYLOAD + sum over j=k..NUM_STAGES of (PROP_j + DRY_j). Computed at elaboration or by a constant function, no runtime adder chain. Arithmetic is unsigned N-bit and wraps silently.
- IDLE:
  - launch -> LOAD at next edge; stage becomes 1 on that edge.
- LOAD (1 cycle):
  - All four parameter outputs are registered from the entry at index stage.
  - stage_valid=1; tick and elapsed_sec are zeroed.
  - -> BURN.
- BURN:
  - burning=1; tick counts 0..TICKS_PER_SEC-1.
  - On wrap, elapsed_sec increments by 1 and saturates at all-ones.
  - Cutoff when ignition_end=1, or when AUTO_CUTOFF=1 and elapsed_sec==burntime. Cutoff -> SEP next edge.
- SEP:
  - Counts SEP_CYCLES cycles, minimum 1.
  - If stage==NUM_STAGES -> DONE; otherwise stage+1 and -> LOAD.
- DONE:
  - mission_done=1; parameter outputs hold the last phase values.
  - launch is ignored. Exit only by reset.
- ABORT:
  - Entered from LOAD/BURN/SEP when abort=1; aborted=1.
  - burning=0; stage and parameter outputs frozen.
  - Exit only by reset.
- Priority within one cycle: reset > abort > cutoff/timer > launch.
  - abort and ignition_end together in BURN -> ABORT.
- Input qualification: launch outside IDLE, ignition_end outside BURN, and abort in IDLE/DONE are all ignored. Inputs are level-sampled; holding one high has no extra effect beyond its state.
- Latency: launch to stage_valid is 2 edges. Cutoff to next stage_valid is SEP_CYCLES+2 edges.

Decomposition:
- Shared package `rocket_pkg`:
  - state enum (IDLE, LOAD, BURN, SEP, DONE, ABORT);
  - table-slice helper function;
  - default Apollo-style table constants.
- Sub-module `burn_timer` (tick + elapsed_sec counters, clear, enable, saturate). Everything else stays in the FSM.

Test Plan (defaults, TICKS_PER_SEC=2, SEP_CYCLES=3; tables Isp=263/421/421/421, prop=2077000/456100/39136/83864, burn=168/360/165/335, dry=137000/40100/0/15200):
- Launch -> stage=1, stage_valid pulse 2 edges after launch, initial_weight=2875403, specific_impulse=263, burntime=168.
- Full auto run:
  - initial_weight per phase = 2875403, 661403, 165203, 126067;
  - each burn lasts burntime*2 cycles;
  - mission_done after phase 4; stage stays 4.
- ignition_end at elapsed_sec=5 in phase 2 -> SEP, then phase 3 loads 5 edges later with weight_propellant=39136.
- abort in BURN phase 3 together with ignition_end -> aborted=1, stage=3, burning=0, held through later launch/ignition_end pulses.
- reset asserted mid-SEP -> next edge shows all reset values; a fresh launch restarts at stage 1.
- AUTO_CUTOFF=0 with burntime=2 -> elapsed_sec passes 2 without cutoff; a later ignition_end ends the burn.

Source files
------------

// File: rtl/rocket_pkg.sv
// Shared types and helpers for the stage sequencer: FSM state encoding,
// packed-table slicing and the default Apollo-style parameter tables.
package rocket_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BURN  = 3'd2,
    SEP   = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_e;

  localparam int unsigned MAX_N      = 128;
  localparam int unsigned MAX_STAGES = 15;
  localparam int unsigned MAX_TBL_W  = MAX_N * MAX_STAGES;

  localparam int unsigned DEF_N      = 64;
  localparam int unsigned DEF_STAGES = 4;

  // Phase k (1-based) of a packed table lives at bits [(k-1)*n +: n].
  function automatic logic [MAX_N-1:0] tbl_slice(input logic [MAX_TBL_W-1:0] tbl,
                                                 input int unsigned k,
                                                 input int unsigned n);
    logic [MAX_TBL_W-1:0] sh;
    logic [MAX_N-1:0]     mask;
    sh   = tbl >> ((k - 1) * n);
    mask = {MAX_N{1'b1}} >> (MAX_N - n);
    return sh[MAX_N-1:0] & mask;
  endfunction

  localparam logic [DEF_STAGES*DEF_N-1:0] DEF_ISP_TABLE =
    {64'd421, 64'd421, 64'd421, 64'd263};
  localparam logic [DEF_STAGES*DEF_N-1:0] DEF_PROP_TABLE =
    {64'd83864, 64'd39136, 64'd456100, 64'd2077000};
  localparam logic [DEF_STAGES*DEF_N-1:0] DEF_BURN_TABLE =
    {64'd335, 64'd165, 64'd360, 64'd168};
  localparam logic [DEF_STAGES*DEF_N-1:0] DEF_DRY_TABLE =
    {64'd15200, 64'd0, 64'd40100, 64'd137000};

endpackage

// File: rtl/burn_timer.sv
// Burn timer: sub-second tick counter plus saturating whole-second counter.
// clear_i wins over enable_i; the counters hold whenever neither is set.
module burn_timer #(
  parameter int unsigned N             = 64,
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  output logic [N-1:0] elapsed_o
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [N-1:0]      elapsed_q, elapsed_d;

  always_comb begin
    tick_d    = tick_q;
    elapsed_d = elapsed_q;
    if (clear_i) begin
      tick_d    = '0;
      elapsed_d = '0;
    end else if (enable_i) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (elapsed_q != {N{1'b1}}) begin
          elapsed_d = elapsed_q + 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q    <= '0;
      elapsed_q <= '0;
    end else begin
      tick_q    <= tick_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-phase burn sequencer: walks IDLE/LOAD/BURN/SEP per phase, publishes
// the phase parameter bus, and parks in DONE or ABORT until reset.
module stage_sequencer
  import rocket_pkg::*;
#(
  parameter int unsigned N             = 64,
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned STAGE_W       = 4,
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned SEP_CYCLES    = 3,
  parameter bit          AUTO_CUTOFF   = 1'b1,
  parameter logic [N-1:0] PAYLOAD      = N'(27003),
  parameter logic [NUM_STAGES*N-1:0] ISP_TABLE  = (NUM_STAGES*N)'(DEF_ISP_TABLE),
  parameter logic [NUM_STAGES*N-1:0] PROP_TABLE = (NUM_STAGES*N)'(DEF_PROP_TABLE),
  parameter logic [NUM_STAGES*N-1:0] BURN_TABLE = (NUM_STAGES*N)'(DEF_BURN_TABLE),
  parameter logic [NUM_STAGES*N-1:0] DRY_TABLE  = (NUM_STAGES*N)'(DEF_DRY_TABLE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               launch,
  input  logic               ignition_end,
  input  logic               abort,
  output logic [STAGE_W-1:0] stage,
  output logic [N-1:0]       specific_impulse,
  output logic [N-1:0]       initial_weight,
  output logic [N-1:0]       weight_propellant,
  output logic [N-1:0]       burntime,
  output logic               stage_valid,
  output logic               burning,
  output logic [N-1:0]       elapsed_sec,
  output logic               mission_done,
  output logic               aborted,
  output state_e             dbg_state_o
);

  localparam int unsigned STAGE_CNT = 2 ** STAGE_W;
  localparam int unsigned SEP_N     = (SEP_CYCLES == 0) ? 1 : SEP_CYCLES;
  localparam int unsigned SEP_W     = (SEP_N > 1) ? $clog2(SEP_N) : 1;
  localparam logic [SEP_W-1:0]   SEP_LAST   = SEP_W'(SEP_N - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] FIRST_STG  = STAGE_W'(1);
  localparam logic [N-1:0]       ONE_N      = N'(1);

  // Mass at ignition of phase k: payload plus everything still stacked below it.
  function automatic logic [N-1:0] init_weight(input int unsigned k);
    logic [N-1:0]     acc;
    logic [MAX_N-1:0] p;
    logic [MAX_N-1:0] d;
    acc = PAYLOAD;
    for (int unsigned j = k; j <= NUM_STAGES; j++) begin
      p   = tbl_slice(MAX_TBL_W'(PROP_TABLE), j, N);
      d   = tbl_slice(MAX_TBL_W'(DRY_TABLE), j, N);
      acc = acc + p[N-1:0] + d[N-1:0];
    end
    return acc;
  endfunction

  logic [N-1:0] isp_tab  [STAGE_CNT];
  logic [N-1:0] prop_tab [STAGE_CNT];
  logic [N-1:0] burn_tab [STAGE_CNT];
  logic [N-1:0] wgt_tab  [STAGE_CNT];

  for (genvar g = 0; g < STAGE_CNT; g++) begin : g_tab
    if (g >= 1 && g <= NUM_STAGES) begin : g_live
      localparam logic [MAX_N-1:0] ISP_V  = tbl_slice(MAX_TBL_W'(ISP_TABLE), g, N);
      localparam logic [MAX_N-1:0] PROP_V = tbl_slice(MAX_TBL_W'(PROP_TABLE), g, N);
      localparam logic [MAX_N-1:0] BURN_V = tbl_slice(MAX_TBL_W'(BURN_TABLE), g, N);
      localparam logic [N-1:0]     WGT_V  = init_weight(g);
      assign isp_tab[g]  = ISP_V[N-1:0];
      assign prop_tab[g] = PROP_V[N-1:0];
      assign burn_tab[g] = BURN_V[N-1:0];
      assign wgt_tab[g]  = WGT_V;
    end else begin : g_pad
      assign isp_tab[g]  = '0;
      assign prop_tab[g] = '0;
      assign burn_tab[g] = '0;
      assign wgt_tab[g]  = '0;
    end
  end

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [N-1:0]       isp_q, isp_d, wgt_q, wgt_d, prop_q, prop_d, burn_q, burn_d;
  logic               stage_valid_q, stage_valid_d;
  logic [SEP_W-1:0]   sep_cnt_q, sep_cnt_d;
  logic [N-1:0]       elapsed_w;
  logic               cutoff, sep_last;
  logic               load_en, timer_en, burning_w, done_w, aborted_w;

  assign cutoff   = ignition_end || (AUTO_CUTOFF && (elapsed_w == burn_q));
  assign sep_last = (sep_cnt_q == SEP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (launch) state_d = LOAD;
      LOAD:  state_d = abort ? ABORT : BURN;
      BURN: begin
        if (abort)       state_d = ABORT;
        else if (cutoff) state_d = SEP;
      end
      SEP: begin
        if (abort)         state_d = ABORT;
        else if (sep_last) state_d = (stage_q == LAST_STAGE) ? DONE : LOAD;
      end
      DONE:    state_d = DONE;
      ABORT:   state_d = ABORT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en   = (state_q == LOAD) && !abort;
    timer_en  = (state_q == BURN);
    burning_w = (state_q == BURN);
    done_w    = (state_q == DONE);
    aborted_w = (state_q == ABORT);
  end

  // stage_valid has no back-pressure: it is a single-cycle pulse coincident
  // with the first cycle the new parameter values are on the bus.
  always_comb begin
    stage_d       = stage_q;
    isp_d         = isp_q;
    wgt_d         = wgt_q;
    prop_d        = prop_q;
    burn_d        = burn_q;
    stage_valid_d = load_en;
    sep_cnt_d     = (state_q == SEP) ? sep_cnt_q + 1'b1 : '0;
    if (state_q == IDLE && launch) begin
      stage_d = FIRST_STG;
    end
    if (state_q == SEP && !abort && sep_last && stage_q != LAST_STAGE) begin
      stage_d = stage_q + 1'b1;
    end
    if (load_en) begin
      isp_d  = isp_tab[stage_q];
      wgt_d  = wgt_tab[stage_q];
      prop_d = prop_tab[stage_q];
      burn_d = burn_tab[stage_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q       <= '0;
      isp_q         <= '0;
      wgt_q         <= '0;
      prop_q        <= '0;
      burn_q        <= ONE_N;
      stage_valid_q <= 1'b0;
      sep_cnt_q     <= '0;
    end else begin
      stage_q       <= stage_d;
      isp_q         <= isp_d;
      wgt_q         <= wgt_d;
      prop_q        <= prop_d;
      burn_q        <= burn_d;
      stage_valid_q <= stage_valid_d;
      sep_cnt_q     <= sep_cnt_d;
    end
  end

  burn_timer #(
    .N            (N),
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (load_en),
    .enable_i (timer_en),
    .elapsed_o(elapsed_w)
  );

  assign stage             = stage_q;
  assign specific_impulse  = isp_q;
  assign initial_weight    = wgt_q;
  assign weight_propellant = prop_q;
  assign burntime          = burn_q;
  assign stage_valid       = stage_valid_q;
  assign burning           = burning_w;
  assign elapsed_sec       = elapsed_w;
  assign mission_done      = done_w;
  assign aborted           = aborted_w;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: randomized missions on a default-table instance
// scored against a table model, plus a manual-cutoff instance.
module tb_stage_sequencer;
  import rocket_pkg::*;

  localparam int N    = 64;
  localparam int NS   = 4;
  localparam int SW   = 4;
  localparam int TPS  = 2;
  localparam int SEPC = 3;
  localparam int RW   = SW + 4 * N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic launch = 1'b0, ignition_end = 1'b0, abort = 1'b0;
  logic launch_b = 1'b0, ignition_end_b = 1'b0;

  logic [SW-1:0] stage_a, stage_b;
  logic [N-1:0]  isp_a, iw_a, prop_a, burn_a, elapsed_a;
  logic [N-1:0]  isp_b, iw_b, prop_b, burn_b, elapsed_b;
  logic          stage_valid_a, burning_a, mission_done_a, aborted_a;
  logic          stage_valid_b, burning_b, mission_done_b, aborted_b;
  state_e        dbg_a, dbg_b;

  stage_sequencer #(
    .N(N), .NUM_STAGES(NS), .STAGE_W(SW), .TICKS_PER_SEC(TPS),
    .SEP_CYCLES(SEPC), .AUTO_CUTOFF(1'b1), .PAYLOAD(64'd27003),
    .ISP_TABLE ({64'd421, 64'd421, 64'd421, 64'd263}),
    .PROP_TABLE({64'd83864, 64'd39136, 64'd456100, 64'd2077000}),
    .BURN_TABLE({64'd335, 64'd165, 64'd360, 64'd168}),
    .DRY_TABLE ({64'd15200, 64'd0, 64'd40100, 64'd137000})
  ) dut_a (
    .clk(clk), .reset(reset), .launch(launch), .ignition_end(ignition_end),
    .abort(abort), .stage(stage_a), .specific_impulse(isp_a),
    .initial_weight(iw_a), .weight_propellant(prop_a), .burntime(burn_a),
    .stage_valid(stage_valid_a), .burning(burning_a), .elapsed_sec(elapsed_a),
    .mission_done(mission_done_a), .aborted(aborted_a), .dbg_state_o(dbg_a)
  );

  stage_sequencer #(
    .N(N), .NUM_STAGES(2), .STAGE_W(SW), .TICKS_PER_SEC(TPS),
    .SEP_CYCLES(0), .AUTO_CUTOFF(1'b0), .PAYLOAD(64'd1000),
    .ISP_TABLE ({64'd200, 64'd300}),
    .PROP_TABLE({64'd50, 64'd100}),
    .BURN_TABLE({64'd2, 64'd2}),
    .DRY_TABLE ({64'd5, 64'd10})
  ) dut_b (
    .clk(clk), .reset(reset), .launch(launch_b), .ignition_end(ignition_end_b),
    .abort(1'b0), .stage(stage_b), .specific_impulse(isp_b),
    .initial_weight(iw_b), .weight_propellant(prop_b), .burntime(burn_b),
    .stage_valid(stage_valid_b), .burning(burning_b), .elapsed_sec(elapsed_b),
    .mission_done(mission_done_b), .aborted(aborted_b), .dbg_state_o(dbg_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [63:0] m_isp [1:4];
  logic [63:0] m_prop[1:4];
  logic [63:0] m_burn[1:4];
  logic [63:0] m_dry [1:4];
  int          mode_tab[1:4];
  logic [63:0] cut_tab [1:4];

  function automatic logic [63:0] m_weight(input int k);
    logic [63:0] w;
    w = 64'd27003;
    for (int j = k; j <= 4; j++) w = w + m_prop[j] + m_dry[j];
    return w;
  endfunction

  task automatic push_exp(input int k);
    exp_q.push_back({SW'(k), m_isp[k], m_weight(k), m_prop[k], m_burn[k]});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [RW-1:0] got;
    logic [RW-1:0] want;
    if (!reset && stage_valid_a) begin
      got = {stage_a, isp_a, iw_a, prop_a, burn_a};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL stage_valid_unexpected: got load of stage %0d, expected none", stage_a);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL phase_params: got stg %0d isp %0d wgt %0d prop %0d burn %0d, expected stg %0d isp %0d wgt %0d prop %0d burn %0d",
                   got[RW-1 -: SW], got[4*N-1 -: N], got[3*N-1 -: N], got[2*N-1 -: N], got[N-1:0],
                   want[RW-1 -: SW], want[4*N-1 -: N], want[3*N-1 -: N], want[2*N-1 -: N], want[N-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset();
    check("rst_stage", 64'(stage_a), 64'd0);
    check("rst_isp", isp_a, 64'd0);
    check("rst_weight", iw_a, 64'd0);
    check("rst_prop", prop_a, 64'd0);
    check("rst_burntime", burn_a, 64'd1);
    check("rst_elapsed", elapsed_a, 64'd0);
    check("rst_valid", 64'(stage_valid_a), 64'd0);
    check("rst_burning", 64'(burning_a), 64'd0);
    check("rst_done", 64'(mission_done_a), 64'd0);
    check("rst_aborted", 64'(aborted_a), 64'd0);
    check("rst_state", 64'(dbg_a), 64'(IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check_reset();
    reset = 1'b0;
  endtask

  task automatic run_mission();
    int cnt;
    bit stop;
    push_exp(1);
    launch = 1'b1;
    step();
    launch = 1'b0;
    check("launch_stage", 64'(stage_a), 64'd1);
    cnt = 1;
    while (!stage_valid_a && cnt < 20) begin step(); cnt++; end
    check("launch_latency", 64'(cnt), 64'd2);
    stop = 1'b0;
    for (int k = 1; k <= 4 && !stop; k++) begin
      int mode;
      mode = mode_tab[k];
      check("burning_in_phase", 64'(burning_a), 64'd1);
      if (mode != 0) begin
        cnt = 0;
        while (elapsed_a != cut_tab[k] && cnt < int'(cut_tab[k]) * TPS + 8) begin step(); cnt++; end
        check("reach_cut_sec", elapsed_a, cut_tab[k]);
        if (mode == 2) begin
          abort = 1'b1;
          ignition_end = 1'b1;
          step();
          abort = 1'b0;
          ignition_end = 1'b0;
          check("abort_flag", 64'(aborted_a), 64'd1);
          check("abort_stage", 64'(stage_a), 64'(k));
          check("abort_burning", 64'(burning_a), 64'd0);
          for (int r = 0; r < 12; r++) begin
            launch = 1'($urandom_range(0, 1));
            ignition_end = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            step();
          end
          launch = 1'b0;
          ignition_end = 1'b0;
          abort = 1'b0;
          step();
          check("abort_hold_flag", 64'(aborted_a), 64'd1);
          check("abort_hold_stage", 64'(stage_a), 64'(k));
          check("abort_hold_burning", 64'(burning_a), 64'd0);
          check("abort_hold_isp", isp_a, m_isp[k]);
          check("abort_hold_prop", prop_a, m_prop[k]);
          check("abort_not_done", 64'(mission_done_a), 64'd0);
          stop = 1'b1;
        end else begin
          if (mode == 1 && k < 4) push_exp(k + 1);
          ignition_end = 1'b1;
          step();
          ignition_end = 1'b0;
          check("cutoff_burning", 64'(burning_a), 64'd0);
          if (mode == 3) begin
            repeat ($urandom_range(0, 2)) step();
            check("in_sep_before_reset", 64'(dbg_a), 64'(SEP));
            reset = 1'b1;
            step();
            reset = 1'b0;
            check_reset();
            stop = 1'b1;
          end
        end
      end else begin
        if (k < 4) push_exp(k + 1);
        cnt = 0;
        while (burning_a && cnt < int'(m_burn[k]) * TPS + 10) begin step(); cnt++; end
        check("auto_cut_burning", 64'(burning_a), 64'd0);
        check("auto_cut_elapsed", elapsed_a, m_burn[k]);
      end
      if (!stop) begin
        cnt = 1;
        if (k < 4) begin
          while (!stage_valid_a && cnt < 20) begin step(); cnt++; end
          check("sep_latency", 64'(cnt), 64'(SEPC + 2));
        end else begin
          while (!mission_done_a && cnt < 20) begin step(); cnt++; end
          check("done_latency", 64'(cnt), 64'(SEPC + 1));
          check("done_stage", 64'(stage_a), 64'd4);
          check("done_burntime", burn_a, m_burn[4]);
          check("done_weight", iw_a, m_weight(4));
          launch = 1'b1;
          step();
          launch = 1'b0;
          repeat (3) step();
          check("done_sticky", 64'(mission_done_a), 64'd1);
          check("done_stage_hold", 64'(stage_a), 64'd4);
          check("done_not_burning", 64'(burning_a), 64'd0);
        end
      end
    end
  endtask

  task automatic run_manual_cutoff();
    int cnt;
    launch_b = 1'b1;
    step();
    launch_b = 1'b0;
    cnt = 1;
    while (!stage_valid_b && cnt < 20) begin step(); cnt++; end
    check("b_launch_latency", 64'(cnt), 64'd2);
    check("b_weight", iw_b, 64'd1000 + 64'd100 + 64'd10 + 64'd50 + 64'd5);
    check("b_burntime", burn_b, 64'd2);
    cnt = 0;
    while (elapsed_b != 64'd4 && cnt < 30) begin step(); cnt++; end
    check("b_elapsed_past_burntime", elapsed_b, 64'd4);
    check("b_still_burning", 64'(burning_b), 64'd1);
    ignition_end_b = 1'b1;
    step();
    ignition_end_b = 1'b0;
    check("b_cut_burning", 64'(burning_b), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_isp  = '{64'd263, 64'd421, 64'd421, 64'd421};
    m_prop = '{64'd2077000, 64'd456100, 64'd39136, 64'd83864};
    m_burn = '{64'd168, 64'd360, 64'd165, 64'd335};
    m_dry  = '{64'd137000, 64'd40100, 64'd0, 64'd15200};

    reset = 1'b1;
    step();
    do_reset();
    check("first_phase_weight_model", m_weight(1), 64'(iw_a) + 64'd2875403);

    run_manual_cutoff();
    do_reset();

    mode_tab = '{0, 0, 0, 0};
    run_mission();
    do_reset();

    mode_tab = '{1, 1, 1, 1};
    cut_tab  = '{64'($urandom_range(1, 8)), 64'd5, 64'($urandom_range(1, 8)), 64'($urandom_range(1, 8))};
    run_mission();
    do_reset();

    mode_tab = '{1, 1, 2, 0};
    cut_tab  = '{64'($urandom_range(1, 8)), 64'($urandom_range(1, 8)), 64'($urandom_range(1, 8)), 64'd1};
    run_mission();
    do_reset();

    mode_tab = '{3, 1, 1, 1};
    cut_tab  = '{64'($urandom_range(1, 8)), 64'd1, 64'd1, 64'd1};
    run_mission();

    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) begin
        mode_tab[k] = ($urandom_range(0, 5) == 0) ? 2 : 1;
        cut_tab[k]  = 64'($urandom_range(1, 8));
      end
      run_mission();
      do_reset();
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
